regfile_wb_arbiter: RTL
=======================

# regfile_wb_arbiter

Write-port arbiter and pending-write scoreboard for the 32x32 register file. It shares the file's single write port (RW/BusW/RegWr) among three writeback sources: ALU, load unit and multiply/divide unit. It also tracks which registers have an outstanding producer so decode can stall on read-after-write hazards. It sits between the writeback sources and the register file, and drives the register file's write inputs directly.

## Interface
- No parameters; requester count fixed at 3, data 32 bits, address 5 bits.
- Clk  in  1  clock. Register file writes on posedge; outputs here are posedge-registered.
- Rst  in  1  synchronous, active-high reset.
- req_valid  in  3  per-requester write request; bit 0 ALU, bit 1 load, bit 2 mul/div.
- req_addr  in  15  packed destination addresses; requester k uses bits [5k+4:5k].
- req_data  in  96  packed write data; requester k uses bits [32k+31:32k].
- req_ready  out  3  combinational grant, one-hot or zero.
- RW  out  5  register file write address, registered.
- BusW  out  32  register file write data, registered.
- RegWr  out  1  register file write enable, registered, one-cycle pulse per write.
- mark_valid  in  1  decode issues an instruction with destination mark_addr.
- mark_addr  in  5  destination to mark pending.
- chk_a, chk_b  in  5 each  source addresses to check, normally RA and RB.
- busy_a, busy_b  out  1 each  combinational; pending bit of chk_a / chk_b.
- pending  out  32  scoreboard vector; bit 0 is always 0.
- err  out  1  sticky protocol-error flag.

## Operation
- Arbitration: at most one requester is granted per cycle, and only valid requesters are granted.
  - Order is set by the configuration below.
  - A transfer occurs when req_valid[k] and req_ready[k] are both high.
  - A requester holds valid, addr and data stable until granted.
- Write issue:
  - On a transfer with address ≠ 0, the next cycle drives RW = addr, BusW = data and RegWr = 1.
  - On a transfer with address 0, the request is consumed and RegWr stays 0 next cycle.
  - With no transfer, RegWr = 0 next cycle, and RW and BusW hold their last values.
- Scoreboard:
  - Set: mark_valid with mark_addr ≠ 0 sets pending[mark_addr] on the posedge.
  - Clear: pending[RW] clears on the posedge ending the cycle in which RegWr = 1. This is the same edge the register file commits on.
  - Set and clear of the same address on the same edge: set wins.
  - Address 0 is never marked.
- Errors (err set, stays 1 until Rst):
  - mark_valid targets an address already pending and not being cleared on that edge.
  - A transfer occurs for a nonzero address whose pending bit is 0.
- busy_a = pending[chk_a], busy_b = pending[chk_b]. Both are pure reads of the current register state, with no bypass of same-cycle set or clear.

## Timing
- Reset values: RegWr 0, RW 0, BusW 0, pending all 0, err 0, round-robin pointer 2 (requester 0 has priority first).
- Rst dominates every other input. An in-flight write whose RegWr is high in the Rst cycle still reaches the register file, which itself clears on that same edge.
- req_ready depends combinationally on req_valid and the pointer only, never on req_data.
- Latency:
  - Transfer in cycle N: RegWr is high during cycle N+1, the register file commits at the end of N+1, and pending clears at the same edge.
  - Decode sees busy drop in cycle N+2.
  - The register file's negedge read in N+2 returns the new value.
- Throughput: one write per cycle sustained. No backpressure from the register file.

## Configuration
- WBARB_ROUND_ROBIN_EN defined:
  - Round-robin priority starts at (last granted + 1) mod 3.
  - The pointer updates only on a transfer.
- Not defined:
  - Fixed priority: requester 0 > 1 > 2, so load and mul/div can starve under continuous ALU traffic.
  - The pointer logic is absent.

## Test plan
- Reset, then a single request: Rst for 2 cycles, then ALU req addr 5 data 0xDEADBEEF.
  - Expect req_ready = 3'b001 that cycle.
  - Next cycle: RegWr = 1, RW = 5, BusW = 0xDEADBEEF. Then RegWr returns to 0.
- Scoreboard round trip: mark addr 7, with chk_a = 7.
  - busy_a = 1 from the next cycle.
  - A load write to 7 is granted in cycle N; busy_a = 0 in N+2. err stays 0.
- Contention, round-robin build: all three valid continuously for 6 cycles, with distinct addresses.
  - Grants 0,1,2,0,1,2. Six RegWr pulses on consecutive cycles.
- Contention, fixed-priority build: same stimulus.
  - Grant stays 3'b001 while ALU valid is high. Load is granted only after ALU drops valid.
- Address 0 and protocol errors:
  - Request to addr 0 is granted, RegWr stays 0, pending[0] stays 0.
  - mark addr 9 twice without a write sets err = 1, which holds until Rst.
- Simultaneous set and clear of addr 3: pending[3] remains 1. Reset mid-operation clears pending and err.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register file's single write port among the
// ALU (requester 0), load unit (1) and mul/div unit (2), and keeps a pending-write
// scoreboard so decode can stall on read-after-write hazards.
// Optional macro WBARB_ROUND_ROBIN_EN selects round-robin arbitration; without
// it the arbiter uses fixed priority 0 > 1 > 2.
module regfile_wb_arbiter (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [2:0]  req_valid,
  input  logic [14:0] req_addr,
  input  logic [95:0] req_data,
  output logic [2:0]  req_ready,
  output logic [4:0]  RW,
  output logic [31:0] BusW,
  output logic        RegWr,
  input  logic        mark_valid,
  input  logic [4:0]  mark_addr,
  input  logic [4:0]  chk_a,
  input  logic [4:0]  chk_b,
  output logic        busy_a,
  output logic        busy_b,
  output logic [31:0] pending,
  output logic        err
);

  logic [4:0]  rw_q, rw_d;
  logic [31:0] busw_q, busw_d;
  logic        regwr_q, regwr_d;
  logic [31:0] pending_q, pending_d;
  logic        err_q, err_d;

  logic [2:0]  grant;
  logic [1:0]  gnt_idx;
  logic        transfer;
  logic [4:0]  sel_addr;
  logic [31:0] sel_data;
  logic        mark_err, wr_err;

`ifdef WBARB_ROUND_ROBIN_EN
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] first;
  logic [2:0] idx;
  logic       found;

  // Round-robin grant: search starts one past the last granted requester.
  always_comb begin
    grant = 3'b000;
    found = 1'b0;
    idx   = 3'd0;
    first = (ptr_q == 2'd2) ? 2'd0 : ptr_q + 2'd1;
    for (int i = 0; i < 3; i++) begin
      idx = {1'b0, first} + 3'(i);
      if (idx >= 3'd3) idx = idx - 3'd3;
      if (!found && req_valid[idx[1:0]]) begin
        grant[idx[1:0]] = 1'b1;
        found = 1'b1;
      end
    end
  end

  // Pointer remembers the last granted requester; it moves only on a transfer.
  always_comb begin
    ptr_d = ptr_q;
    if (transfer) ptr_d = gnt_idx;
  end

  // Pointer register; reset value 2 gives requester 0 first priority.
  always_ff @(posedge Clk) begin
    if (Rst) ptr_q <= 2'd2;
    else     ptr_q <= ptr_d;
  end
`else
  // Fixed-priority grant: lowest-numbered valid requester wins.
  always_comb begin
    grant = 3'b000;
    if (req_valid[0])      grant = 3'b001;
    else if (req_valid[1]) grant = 3'b010;
    else if (req_valid[2]) grant = 3'b100;
  end
`endif

  assign req_ready = grant;
  assign transfer  = |grant;

  // Select the granted requester's address and data.
  always_comb begin
    gnt_idx  = 2'd0;
    sel_addr = req_addr[4:0];
    sel_data = req_data[31:0];
    if (grant[1]) begin
      gnt_idx  = 2'd1;
      sel_addr = req_addr[9:5];
      sel_data = req_data[63:32];
    end else if (grant[2]) begin
      gnt_idx  = 2'd2;
      sel_addr = req_addr[14:10];
      sel_data = req_data[95:64];
    end
  end

  // Next-state for write port, scoreboard and error flag.
  always_comb begin
    regwr_d = transfer && (sel_addr != 5'd0);
    rw_d    = regwr_d ? sel_addr : rw_q;
    busw_d  = regwr_d ? sel_data : busw_q;

    // Clear the bit being committed this edge; a same-edge mark overrides it.
    pending_d = pending_q;
    if (regwr_q) pending_d[rw_q] = 1'b0;
    if (mark_valid && (mark_addr != 5'd0)) pending_d[mark_addr] = 1'b1;
    pending_d[0] = 1'b0;

    mark_err = mark_valid && (mark_addr != 5'd0) && pending_q[mark_addr] &&
               !(regwr_q && (rw_q == mark_addr));
    wr_err   = transfer && (sel_addr != 5'd0) && !pending_q[sel_addr];
    err_d    = err_q | mark_err | wr_err;
  end

  // State registers; Rst overrides every input.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      rw_q      <= 5'd0;
      busw_q    <= 32'd0;
      regwr_q   <= 1'b0;
      pending_q <= 32'd0;
      err_q     <= 1'b0;
    end else begin
      rw_q      <= rw_d;
      busw_q    <= busw_d;
      regwr_q   <= regwr_d;
      pending_q <= pending_d;
      err_q     <= err_d;
    end
  end

  assign RW      = rw_q;
  assign BusW    = busw_q;
  assign RegWr   = regwr_q;
  assign pending = pending_q;
  assign err     = err_q;
  assign busy_a  = pending_q[chk_a];
  assign busy_b  = pending_q[chk_b];

endmodule
